// File: rtl/multi_pulse_width_detector.sv
// multi_pulse_width_detector
// N independent channels, each watched for rising, falling or any edge, or for
// a high pulse whose length lies inside [min_len, max_len]. The detection strobe
// is combinational (zero latency). The sticky flags and the high-run counters
// are registered.
module multi_pulse_width_detector #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     min_len,
  input  logic [CNT_W-1:0]     max_len,
  input  logic [N-1:0]         clr,
  output logic [N-1:0]         detected,
  output logic [N*CNT_W-1:0]   pulse_len,
  output logic [N-1:0]         sticky
);

  // A counter at this value means "run too long to measure". Such a run never
  // matches the pulse window.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_ANY   = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  // Next high-run count: increment while high (saturating), zero on a low sample.
  function automatic logic [CNT_W-1:0] cnt_next(input logic a_bit,
                                                input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (!a_bit) begin
      res = {CNT_W{1'b0}};
    end else if (cnt == CNT_MAX) begin
      res = CNT_MAX;
    end else begin
      res = cnt + CNT_W'(1);
    end
    return res;
  endfunction

  // Inclusive window test. A saturated count is excluded. An inverted window
  // (lo > hi) naturally never hits.
  function automatic logic window_hit(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi) && (cnt != CNT_MAX);
  endfunction

  logic [N-1:0]     a_q, a_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     sticky_q, sticky_d;
  logic [N-1:0]     hit_s;
  logic [N-1:0]     rise_s, fall_s;
  logic [N-1:0]     det_s;

  // Per-channel edge terms and pulse-window comparison against the stored run length.
  always_comb begin
    rise_s = a & ~a_q;
    fall_s = ~a & a_q;
    hit_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      hit_s[i] = window_hit(cnt_q[i], min_len, max_len);
    end
  end

  // Mode-selected detection strobe. It is held low during reset.
  always_comb begin
    det_s = {N{1'b0}};
    if (rst) begin
      det_s = {N{1'b0}};
    end else begin
      case (mode_e'(mode))
        MODE_RISE:  det_s = rise_s;
        MODE_FALL:  det_s = fall_s;
        MODE_ANY:   det_s = a ^ a_q;
        MODE_PULSE: det_s = fall_s & hit_s;
        default:    det_s = {N{1'b0}};
      endcase
    end
  end

  // Next-state history. The counter runs in every mode. On sticky, set wins over clear.
  always_comb begin
    a_d      = a;
    sticky_d = (sticky_q & ~clr) | det_s;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_next(a[i], cnt_q[i]);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= {N{1'b0}};
      sticky_q <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      a_q      <= a_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack the per-channel run lengths onto the flat output bus.
  always_comb begin
    pulse_len = {(N*CNT_W){1'b0}};
    for (int i = 0; i < N; i++) begin
      pulse_len[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign detected = det_s;
  assign sticky   = sticky_q;

endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// Self-checking bench for multi_pulse_width_detector (N=4, CNT_W=4).
// The reference model tracks each channel's previous level and its unbounded
// high-run length. It derives the expected strobe, run length and sticky flag
// from those values.
module tb_multi_pulse_width_detector;

  logic        clk;
  logic        rst;
  logic [3:0]  a;
  logic [1:0]  mode;
  logic [3:0]  min_len;
  logic [3:0]  max_len;
  logic [3:0]  clr;
  logic [3:0]  detected;
  logic [15:0] pulse_len;
  logic [3:0]  sticky;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0] m_prev;
  int         m_run [4];
  logic [3:0] m_stk;

  // last observed DUT outputs, sampled on the falling edge
  logic [3:0]  obs_det;
  logic [15:0] obs_len;
  logic [3:0]  obs_stk;

  multi_pulse_width_detector #(.N(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .a(a), .mode(mode), .min_len(min_len),
    .max_len(max_len), .clr(clr), .detected(detected),
    .pulse_len(pulse_len), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_prev = 4'd0;
    m_stk  = 4'd0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [3:0] av, input logic [1:0] m,
                      input logic [3:0] mn, input logic [3:0] mx, input logic [3:0] cl);
    logic [3:0]  e_det;
    logic [15:0] e_len;
    rst = r; a = av; mode = m; min_len = mn; max_len = mx; clr = cl;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e_len[i*4 +: 4] = (m_run[i] > 15) ? 4'd15 : 4'(m_run[i]);
      case (m)
        2'b00:   e_det[i] = av[i] && !m_prev[i];
        2'b01:   e_det[i] = !av[i] && m_prev[i];
        2'b10:   e_det[i] = av[i] != m_prev[i];
        default: e_det[i] = !av[i] && m_prev[i] && (m_run[i] >= int'(mn)) &&
                            (m_run[i] <= int'(mx)) && (m_run[i] < 15);
      endcase
      if (r) e_det[i] = 1'b0;
    end
    obs_det = detected; obs_len = pulse_len; obs_stk = sticky;
    n_checks++;
    if (obs_det !== e_det) begin
      n_fail++;
      $display("FAIL detected @%0t: got %b, want %b", $time, obs_det, e_det);
    end
    n_checks++;
    if (obs_len !== e_len) begin
      n_fail++;
      $display("FAIL pulse_len @%0t: got %h, want %h", $time, obs_len, e_len);
    end
    n_checks++;
    if (obs_stk !== m_stk) begin
      n_fail++;
      $display("FAIL sticky @%0t: got %b, want %b", $time, obs_stk, m_stk);
    end
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = av[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
      end
      m_prev = av;
      m_stk  = (m_stk & ~cl) | e_det;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 4'hF, 2'b00, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_det !== 4'h0) begin
      n_fail++; $display("FAIL reset_det: got %b, want 0000", obs_det);
    end
    step(1'b0, 4'h0, 2'b00, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_len !== 16'h0 || obs_stk !== 4'h0) begin
      n_fail++; $display("FAIL reset_state: len %h stk %b, want 0", obs_len, obs_stk);
    end
  endtask

  task automatic test_edge_modes();
    logic [4:0] seq;
    logic [4:0] exp_pat [3];
    seq = 5'b10110;
    exp_pat[0] = 5'b10010;
    exp_pat[1] = 5'b01000;
    exp_pat[2] = 5'b11010;
    for (int md = 0; md < 3; md++) begin
      step(1'b1, 4'h0, 2'(md), 4'd1, 4'd15, 4'h0);
      for (int s = 0; s < 5; s++) begin
        step(1'b0, {3'b000, seq[s]}, 2'(md), 4'd1, 4'd15, 4'h0);
        n_checks++;
        if (obs_det !== {3'b000, exp_pat[md][s]}) begin
          n_fail++;
          $display("FAIL edge_mode%0d sample%0d: got %b, want %b", md, s + 1, obs_det,
                   {3'b000, exp_pat[md][s]});
        end
      end
    end
  endtask

  task automatic test_one_cycle_pulse();
    logic [6:0] seq;
    seq = 7'b0110010;
    step(1'b1, 4'h0, 2'b11, 4'd1, 4'd1, 4'h0);
    for (int s = 0; s < 7; s++) begin
      step(1'b0, {2'b00, seq[s], 1'b0}, 2'b11, 4'd1, 4'd1, 4'h0);
      n_checks++;
      if (obs_det[1] !== (s == 2)) begin
        n_fail++; $display("FAIL one_cycle sample%0d: got %b, want %b", s + 1, obs_det[1], s == 2);
      end
    end
    n_checks++;
    if (obs_len[7:4] !== 4'd2) begin
      n_fail++; $display("FAIL one_cycle_len2: got %0d, want 2", obs_len[7:4]);
    end
  endtask

  task automatic test_saturation();
    int lens [3];
    lens[0] = 20; lens[1] = 15; lens[2] = 14;
    step(1'b1, 4'h0, 2'b11, 4'd3, 4'd15, 4'h0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < lens[k]; c++) step(1'b0, 4'b0100, 2'b11, 4'd3, 4'd15, 4'h0);
      step(1'b0, 4'h0, 2'b11, 4'd3, 4'd15, 4'h0);
      n_checks++;
      if (obs_det[2] !== (k == 2) ||
          obs_len[11:8] !== ((lens[k] > 15) ? 4'd15 : 4'(lens[k]))) begin
        n_fail++;
        $display("FAIL saturation run%0d: det %b len %0d", lens[k], obs_det[2], obs_len[11:8]);
      end
      step(1'b0, 4'h0, 2'b11, 4'd3, 4'd15, 4'h0);
    end
  endtask

  task automatic test_sticky();
    step(1'b0, 4'h0, 2'b00, 4'd1, 4'd15, 4'hF);
    step(1'b0, 4'b1000, 2'b00, 4'd1, 4'd15, 4'h0);
    step(1'b0, 4'b1000, 2'b00, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_stk[3] !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set: got %b, want 1", obs_stk[3]);
    end
    step(1'b0, 4'b1000, 2'b00, 4'd1, 4'd15, 4'b1000);
    step(1'b0, 4'b1000, 2'b00, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_stk[3] !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear: got %b, want 0", obs_stk[3]);
    end
    step(1'b0, 4'h0, 2'b00, 4'd1, 4'd15, 4'h0);
    step(1'b0, 4'b1000, 2'b00, 4'd1, 4'd15, 4'b1000);
    step(1'b0, 4'b1000, 2'b00, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_stk[3] !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set_wins: got %b, want 1", obs_stk[3]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    step(1'b0, 4'h0, 2'b11, 4'd1, 4'd15, 4'hF);
    step(1'b0, 4'b0001, 2'b11, 4'd1, 4'd15, 4'h0);
    step(1'b1, 4'b0001, 2'b11, 4'd1, 4'd15, 4'h0);
    step(1'b0, 4'b0001, 2'b11, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_det !== 4'h0 || obs_stk !== 4'h0 || obs_len !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_pulse: det %b stk %b len %h", obs_det, obs_stk, obs_len);
    end
    step(1'b0, 4'h0, 2'b11, 4'd1, 4'd15, 4'h0);
    n_checks++;
    if (obs_len[3:0] !== 4'd1) begin
      n_fail++; $display("FAIL rst_post_len: got %0d, want 1", obs_len[3:0]);
    end
  endtask

  task automatic test_empty_window();
    for (int l = 1; l <= 6; l++) begin
      for (int c = 0; c < l; c++) step(1'b0, 4'hF, 2'b11, 4'd5, 4'd2, 4'h0);
      step(1'b0, 4'h0, 2'b11, 4'd5, 4'd2, 4'h0);
      n_checks++;
      if (obs_det !== 4'h0) begin
        n_fail++; $display("FAIL empty_window len%0d: got %b, want 0000", l, obs_det);
      end
    end
    step(1'b0, 4'hF, 2'b00, 4'd5, 4'd2, 4'h0);
    n_checks++;
    if (obs_det !== 4'hF) begin
      n_fail++; $display("FAIL mode_change_rise: got %b, want 1111", obs_det);
    end
  endtask

  task automatic test_random();
    logic [3:0] av, cl, mn, mx;
    logic [1:0] m;
    logic       r;
    av = 4'h0; m = 2'b11; mn = 4'd2; mx = 4'd6;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) < 3) av[i] = ~av[i];
      end
      if ($urandom_range(0, 24) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        mn = 4'($urandom_range(0, 15));
        mx = 4'($urandom_range(0, 15));
      end
      cl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      r  = ($urandom_range(0, 79) == 0);
      step(r, av, m, mn, mx, cl);
    end
  endtask

  initial begin
    rst = 1'b1; a = 4'h0; mode = 2'b00; min_len = 4'd1; max_len = 4'd15; clr = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    test_reset();
    test_edge_modes();
    test_one_cycle_pulse();
    test_saturation();
    test_sticky();
    test_reset_mid_pulse();
    test_empty_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
